rr_select_arbiter: RTL and testbench
====================================

// Module: rr_select_arbiter
// PURPOSE
//   Round-robin arbiter that drives the 3-bit select of the 8:1 mux tree.
//   It grants one of N requesting channels at a time and holds sel stable
//   until the consumer acknowledges. It then advances fairness priority to
//   the next channel. Sits directly upstream of mux8to1: sel -> select,
//   and the consumer samples the mux out while grant_valid=1.
// PARAMETERS
//   N         8    number of request channels (power of two, 2..8)
//   SEL_W     3    select width, = log2(N)
//   TIMEOUT   16   watchdog limit in cycles; used only with RR_ARB_TIMEOUT_EN
// PORTS
//   clk           in   1      rising-edge clock, single clock domain
//   rst_n         in   1      asynchronous active-low reset
//   req           in   N      per-channel request, level-sensitive
//   grant_ack     in   1      consumer done with the current grant
//   sel           out  SEL_W  registered channel index -> mux select
//   grant_valid   out  1      sel holds a live grant
//   grant_onehot  out  N      one-hot of sel when grant_valid=1, else 0
//   timeout       out  1      1-cycle pulse on watchdog release (macro only)
// BEHAVIOUR
//   Reset (async assert, sync release):
//     state=IDLE; ptr=0; sel=0; grant_valid=0; grant_onehot=0; timeout=0.
//   All outputs are registered. sel never changes while grant_valid=1.
//   FSM states: IDLE and GRANT.
//   - IDLE, req==0: stay in IDLE; sel holds its last value.
//   - IDLE, req!=0:
//       winner = first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1
//       (modulo N).
//       Next edge: sel=winner, grant_valid=1, state=GRANT.
//       Latency from req sampled to grant_valid: 1 cycle.
//   - GRANT, grant_ack=1:
//       Next edge: grant_valid=0, ptr=(sel+1) mod N (wraps 7->0), state=IDLE.
//   - GRANT, grant_ack=0, req[sel]=0 (request withdrawn):
//       Next edge: grant_valid=0, state=IDLE, ptr unchanged.
//   - GRANT, grant_ack=1 and req[sel]=0 on the same cycle: treated as an ack.
//   - Other requests arriving during GRANT are ignored until IDLE.
//   - There is always at least 1 IDLE cycle between grants, so grant_valid
//     is low for >=1 cycle after every release.
//   - grant_ack while in IDLE is ignored and has no effect on ptr.
//   - A single persistent requester k is re-granted every 2 cycles.
//   - rst_n asserted mid-grant: grant_valid drops immediately (async) and
//     ptr returns to 0.
// CONFIGURATION
//   RR_ARB_TIMEOUT_EN defined:
//     - A cycle counter (width = log2(TIMEOUT)+1) clears on entry to GRANT
//       and increments each GRANT cycle.
//     - When the counter reaches TIMEOUT-1 with no ack: next edge releases
//       exactly as an ack (ptr=sel+1 mod N) and pulses timeout=1 for 1 cycle.
//     - An ack on the same cycle as expiry takes precedence: no timeout pulse.
//   RR_ARB_TIMEOUT_EN undefined:
//     - No counter logic is built. Grants are held indefinitely.
//     - The timeout port is still present, tied to 0.
// TESTING
//   1 Reset: rst_n=0, then release with req=0 -> sel=0, grant_valid=0,
//     grant_onehot=0 for 5 cycles.
//   2 Fairness: req=8'hFF, ack 1 cycle after each grant -> sel sequence
//     0,1,2,...,7,0; each grant_valid pulse separated by 1 IDLE cycle.
//   3 Wrap/skip: ptr=6 (after granting 5), req=8'b0000_0101 -> sel=0,
//     then 2; channels 6, 7, 1 are never granted.
//   4 Hold: grant sel=3, change req to 8'h80 while ack=0 but req[3]=1 ->
//     sel remains 3 until ack; next grant is sel=7.
//   5 Withdraw: grant sel=4, drop req[4] with ack=0 -> grant_valid=0 next
//     cycle; with req=8'h30 the next grant is sel=4 again (ptr not advanced).
//   6 Timeout (macro on, TIMEOUT=16): hold req=8'h02, never ack ->
//     grant_valid falls after 16 GRANT cycles with a timeout pulse;
//     sel=1 is re-granted after 1 IDLE cycle.
//     Reset asserted mid-grant -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rr_select_arbiter.sv
// rr_select_arbiter
//   Round-robin arbiter that drives the select of the 8:1 mux tree. It grants
//   one requesting channel at a time and holds sel stable until the consumer
//   acknowledges. On acknowledge it moves fairness priority to the channel
//   after the one just served. The consumer samples the mux output while
//   grant_valid=1.
//
// Parameters
//   N        number of request channels (power of two, 2..8)
//   SEL_W    select width, log2(N)
//   TIMEOUT  watchdog limit in GRANT cycles (RR_ARB_TIMEOUT_EN only)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req[N]        per-channel level-sensitive request
//   grant_ack     consumer is done with the current grant
//   sel[SEL_W]    registered channel index -> mux select
//   grant_valid   sel holds a live grant
//   grant_onehot  one-hot of sel while grant_valid=1, else 0
//   timeout       1-cycle pulse on watchdog release
//
// Build option
//   RR_ARB_TIMEOUT_EN  when defined, a watchdog releases a grant after TIMEOUT
//                      GRANT cycles without an ack. When undefined, grants are
//                      held indefinitely and timeout is tied to 0.

module rr_select_arbiter #(
  parameter int N       = 8,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             grant_ack,
  output logic [SEL_W-1:0] sel,
  output logic             grant_valid,
  output logic [N-1:0]     grant_onehot,
  output logic             timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [SEL_W-1:0] sel_n;
  logic             gv_n;
  logic [N-1:0]     oh_n;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] idx;
  logic             found;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             to_n;
`endif

  // Rotating priority scan starting at ptr. N is a power of two, so the
  // SEL_W-bit add wraps modulo N on its own.
  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    gv_n    = grant_valid;
    oh_n    = grant_onehot;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_n   = cnt;
    to_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_n      = GRANT;
          sel_n        = winner;
          gv_n         = 1'b1;
          oh_n         = '0;
          oh_n[winner] = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_n        = '0;
`endif
        end
      end
      GRANT: begin
        // Ack wins over a simultaneous withdraw or watchdog expiry.
        if (grant_ack) begin
          state_n = IDLE;
          gv_n    = 1'b0;
          oh_n    = '0;
          ptr_n   = sel + 1'b1;
        end else if (!req[sel]) begin
          state_n = IDLE;
          gv_n    = 1'b0;
          oh_n    = '0;
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_n = IDLE;
          gv_n    = 1'b0;
          oh_n    = '0;
          ptr_n   = sel + 1'b1;
          to_n    = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_n = IDLE;
        gv_n    = 1'b0;
        oh_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      sel          <= '0;
      grant_valid  <= 1'b0;
      grant_onehot <= '0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      sel          <= sel_n;
      grant_valid  <= gv_n;
      grant_onehot <= oh_n;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      timeout <= to_n;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Testbench for rr_select_arbiter: table-driven cycle vectors plus hand-written
// multi-cycle sequences. Expected outputs are queued when inputs are driven
// and popped after the following rising edge.

module tb_rr_select_arbiter;
  localparam int N       = 8;
  localparam int SEL_W   = 3;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic             grant_ack = 1'b0;
  logic [SEL_W-1:0] sel;
  logic             grant_valid;
  logic [N-1:0]     grant_onehot;
  logic             timeout;

  always #5 clk = ~clk;

  rr_select_arbiter #(.N(N), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant_ack(grant_ack),
    .sel(sel), .grant_valid(grant_valid), .grant_onehot(grant_onehot),
    .timeout(timeout)
  );

  typedef struct {
    logic [7:0] req;
    logic       ack;
    logic [2:0] sel;
    logic       gv;
    logic [7:0] oh;
    logic       to;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] sel;
    logic       gv;
    logic [7:0] oh;
    logic       to;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [7:0] oh(input int k);
    logic [7:0] v;
    v = 8'd1;
    return v << k;
  endfunction

  task automatic chk(input string name, input string field,
                     input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", name, field, got, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    chk(e.name, "sel", 8'(sel), 8'(e.sel));
    chk(e.name, "grant_valid", 8'(grant_valid), 8'(e.gv));
    chk(e.name, "grant_onehot", grant_onehot, e.oh);
    chk(e.name, "timeout", 8'(timeout), 8'(e.to));
  endtask

  task automatic step(input string name, input logic [7:0] r, input logic a,
                      input logic [2:0] es, input logic egv,
                      input logic [7:0] eoh, input logic eto);
    exp_t e;
    @(negedge clk);
    req       = r;
    grant_ack = a;
    e.name = name; e.sel = es; e.gv = egv; e.oh = eoh; e.to = eto;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s.scoreboard: got empty queue expected entry", name);
    end else begin
      e = sb.pop_front();
      check_outputs(e);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] r, input logic a,
                              input logic [2:0] s, input logic gv,
                              input logic [7:0] o);
    vec_t v;
    v.req = r; v.ack = a; v.sel = s; v.gv = gv; v.oh = o; v.to = 1'b0;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    exp_t e;

    // Fairness over all channels: grant k, ack it, grant k+1 ... wrapping to 0.
    for (int i = 0; i <= 8; i++) begin
      tbl.push_back(mk(8'hFF, 1'b0, 3'(i % 8), 1'b1, oh(i % 8)));
      tbl.push_back(mk(8'hFF, 1'b1, 3'(i % 8), 1'b0, 8'h00));
    end
    // Grant 5 so ptr=6, then req 0 and 2 only: scan wraps past 6,7 to 0, then 2.
    tbl.push_back(mk(8'h20, 1'b0, 3'd5, 1'b1, oh(5)));
    tbl.push_back(mk(8'h20, 1'b1, 3'd5, 1'b0, 8'h00));
    tbl.push_back(mk(8'h05, 1'b0, 3'd0, 1'b1, oh(0)));
    tbl.push_back(mk(8'h05, 1'b1, 3'd0, 1'b0, 8'h00));
    tbl.push_back(mk(8'h05, 1'b0, 3'd2, 1'b1, oh(2)));
    tbl.push_back(mk(8'h05, 1'b1, 3'd2, 1'b0, 8'h00));

    // Reset held, then released with no requests.
    #2;
    e.name = "reset_asserted"; e.sel = 3'd0; e.gv = 1'b0; e.oh = 8'h00; e.to = 1'b0;
    check_outputs(e);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("reset_idle", 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);

    foreach (tbl[i]) step($sformatf("table[%0d]", i), tbl[i].req, tbl[i].ack,
                          tbl[i].sel, tbl[i].gv, tbl[i].oh, tbl[i].to);

    // Hold: ptr=3. Other requests appear mid-grant; sel stays 3 until ack.
    step("hold_grant", 8'h08, 1'b0, 3'd3, 1'b1, oh(3), 1'b0);
    for (int i = 0; i < 3; i++) step("hold_keep", 8'h88, 1'b0, 3'd3, 1'b1, oh(3), 1'b0);
    step("hold_ack", 8'h88, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0);
    step("hold_next", 8'h80, 1'b0, 3'd7, 1'b1, oh(7), 1'b0);
    step("hold_next_ack", 8'h80, 1'b1, 3'd7, 1'b0, 8'h00, 1'b0);

    // Withdraw: ptr=0, grant 4, drop req[4]; ptr must not advance.
    step("wd_grant", 8'h10, 1'b0, 3'd4, 1'b1, oh(4), 1'b0);
    step("wd_drop", 8'h00, 1'b0, 3'd4, 1'b0, 8'h00, 1'b0);
    step("wd_regrant", 8'h30, 1'b0, 3'd4, 1'b1, oh(4), 1'b0);
    step("wd_ack", 8'h30, 1'b1, 3'd4, 1'b0, 8'h00, 1'b0);

    // Ack in IDLE must not move ptr (ptr=5).
    step("idle_ack", 8'h00, 1'b1, 3'd4, 1'b0, 8'h00, 1'b0);
    step("idle_ack_grant", 8'hFF, 1'b0, 3'd5, 1'b1, oh(5), 1'b0);
    step("idle_ack_rel", 8'hFF, 1'b1, 3'd5, 1'b0, 8'h00, 1'b0);

    // Persistent single requester with ack held high: grant every 2 cycles.
    for (int i = 0; i < 2; i++) begin
      step("persist_grant", 8'h04, 1'b1, 3'd2, 1'b1, oh(2), 1'b0);
      step("persist_rel", 8'h04, 1'b1, 3'd2, 1'b0, 8'h00, 1'b0);
    end

    // Never acked grant on channel 1 (ptr=3).
    step("to_grant", 8'h02, 1'b0, 3'd1, 1'b1, oh(1), 1'b0);
    for (int i = 2; i <= 20; i++) begin
`ifdef RR_ARB_TIMEOUT_EN
      if (i <= 16)      step("to_hold", 8'h02, 1'b0, 3'd1, 1'b1, oh(1), 1'b0);
      else if (i == 17) step("to_fire", 8'h02, 1'b0, 3'd1, 1'b0, 8'h00, 1'b1);
      else              step("to_regrant", 8'h02, 1'b0, 3'd1, 1'b1, oh(1), 1'b0);
`else
      step("no_to_hold", 8'h02, 1'b0, 3'd1, 1'b1, oh(1), 1'b0);
`endif
    end
    step("to_ack", 8'h02, 1'b1, 3'd1, 1'b0, 8'h00, 1'b0);

    // Ack exactly on the expiry cycle: released, no timeout pulse (ptr=2).
    step("prec_grant", 8'h02, 1'b0, 3'd1, 1'b1, oh(1), 1'b0);
    for (int i = 0; i < 15; i++) step("prec_hold", 8'h02, 1'b0, 3'd1, 1'b1, oh(1), 1'b0);
    step("prec_ack", 8'h02, 1'b1, 3'd1, 1'b0, 8'h00, 1'b0);

    // Reset mid-grant: outputs clear without a clock edge, ptr returns to 0.
    step("rst_grant", 8'h02, 1'b0, 3'd1, 1'b1, oh(1), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    e.name = "rst_async"; e.sel = 3'd0; e.gv = 1'b0; e.oh = 8'h00; e.to = 1'b0;
    check_outputs(e);
    req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_ptr0", 8'hFF, 1'b0, 3'd0, 1'b1, oh(0), 1'b0);
    step("rst_ptr0_ack", 8'hFF, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
